// File: rtl/multiword_add_ctrl.sv
// multiword_add_ctrl: wide add/subtract sequenced over one narrow adder.
// A SIZE-bit adder is reused CHUNKS times, least-significant chunk first,
// with a carry register linking consecutive chunks. Results are registered
// when the last chunk completes and are presented during the DONE cycle.
module multiword_add_ctrl #(
    parameter int SIZE   = 4,
    parameter int CHUNKS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sub,
    input  logic [SIZE*CHUNKS-1:0] a,
    input  logic [SIZE*CHUNKS-1:0] b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [SIZE*CHUNKS-1:0] sum,
    output logic                   cout,
    output logic                   ovf
);

    localparam int W    = SIZE * CHUNKS;
    localparam int IDXW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [W-1:0]      opa_q, opa_d;
    logic [W-1:0]      opb_q, opb_d;
    logic [W-1:0]      res_q, res_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [SIZE-1:0]   ch_a;
    logic [SIZE-1:0]   ch_b;
    logic [SIZE:0]     ch_full;
    logic [SIZE-1:0]   ch_sum;
    logic              ch_co;
    logic              ch_cmsb;
    logic              last_chunk;

    // Chunk selection and the shared SIZE-bit adder.
    assign ch_a       = opa_q[int'(idx_q)*SIZE +: SIZE];
    assign ch_b       = opb_q[int'(idx_q)*SIZE +: SIZE];
    assign ch_full    = {1'b0, ch_a} + {1'b0, ch_b} + {{SIZE{1'b0}}, carry_q};
    assign ch_sum     = ch_full[SIZE-1:0];
    assign ch_co      = ch_full[SIZE];
    // Carry into the chunk MSB, recovered from the MSB sum bit.
    assign ch_cmsb    = ch_a[SIZE-1] ^ ch_b[SIZE-1] ^ ch_sum[SIZE-1];
    assign last_chunk = (idx_q == IDXW'(CHUNKS - 1));

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d   = a;
                    // Subtract as A + ~B + 1: invert B and force carry-in.
                    opb_d   = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[int'(idx_q)*SIZE +: SIZE] = ch_sum;
                carry_d = ch_co;
                if (last_chunk) begin
                    sum_d   = res_d;
                    cout_d  = ch_co;
                    ovf_d   = ch_cmsb ^ ch_co;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control, carry and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operand latches; only meaningful after an accept, so no reset.
    always_ff @(posedge clk) begin
        opa_q <= opa_d;
        opb_q <= opb_d;
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
